// File: rtl/prefix_tree_pipe_4b_if.sv
// Handshake bundle for prefix_tree_pipe_4b: operands in, sum/carry out.
// zero_o / ovf_o exist only when PREFIX_FLAGS_EN is defined.
interface prefix_tree_pipe_4b_if;
    logic       valid_i;
    logic       ready_o;
    logic [4:0] prop_i;
    logic [4:0] gen_i;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] sum_o;
    logic       carry_o;
`ifdef PREFIX_FLAGS_EN
    logic       zero_o;
    logic       ovf_o;

    modport master (
        output valid_i, prop_i, gen_i, ready_i,
        input  ready_o, valid_o, sum_o, carry_o,
        input  zero_o, ovf_o
    );

    modport slave (
        input  valid_i, prop_i, gen_i, ready_i,
        output ready_o, valid_o, sum_o, carry_o,
        output zero_o, ovf_o
    );
`else
    modport master (
        output valid_i, prop_i, gen_i, ready_i,
        input  ready_o, valid_o, sum_o, carry_o
    );

    modport slave (
        input  valid_i, prop_i, gen_i, ready_i,
        output ready_o, valid_o, sum_o, carry_o
    );
`endif
endinterface

// File: rtl/prefix_tree_pipe_4b.sv
// Pipelined 3-level Kogge-Stone carry tree plus sum/carry post-processing.
// Define PREFIX_FLAGS_EN to add the registered zero_o / ovf_o flags.
module prefix_tree_pipe_4b #(
    parameter bit OUT_REG = 1'b1
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    prefix_tree_pipe_4b_if.slave bus
);

    typedef struct packed {
        logic [4:0] g;
        logic [4:0] p;
        logic [3:0] po;
    } pg_t;

    pg_t  in_pg;
    pg_t  l1;
    pg_t  l2;
    pg_t  l3;
    pg_t  s1;
    pg_t  s2;
    pg_t  s3;
    logic v1;
    logic v2;
    logic v3;
    logic ld1;
    logic ld2;
    logic ld3;
    logic ld_tail;

    logic [3:0] post_sum;
    logic       post_carry;
`ifdef PREFIX_FLAGS_EN
    logic       post_zero;
    logic       post_ovf;
`endif
    logic       unused_bits;

    function automatic logic [1:0] op(
        input logic ghi,
        input logic phi,
        input logic glo,
        input logic plo
    );
        return {ghi | (phi & glo), phi & plo};
    endfunction

    // Position 0 carries cin only; its propagate is forced low.
    always_comb begin
        in_pg    = '0;
        in_pg.g  = bus.gen_i;
        in_pg.p  = {bus.prop_i[4:1], 1'b0};
        in_pg.po = bus.prop_i[4:1];
    end

    always_comb begin
        l1 = in_pg;
        {l1.g[1], l1.p[1]} = op(in_pg.g[1], in_pg.p[1],
                                in_pg.g[0], in_pg.p[0]);
        {l1.g[2], l1.p[2]} = op(in_pg.g[2], in_pg.p[2],
                                in_pg.g[1], in_pg.p[1]);
        {l1.g[3], l1.p[3]} = op(in_pg.g[3], in_pg.p[3],
                                in_pg.g[2], in_pg.p[2]);
        {l1.g[4], l1.p[4]} = op(in_pg.g[4], in_pg.p[4],
                                in_pg.g[3], in_pg.p[3]);
    end

    always_comb begin
        l2 = s1;
        {l2.g[2], l2.p[2]} = op(s1.g[2], s1.p[2], s1.g[0], s1.p[0]);
        {l2.g[3], l2.p[3]} = op(s1.g[3], s1.p[3], s1.g[1], s1.p[1]);
        {l2.g[4], l2.p[4]} = op(s1.g[4], s1.p[4], s1.g[2], s1.p[2]);
    end

    always_comb begin
        l3 = s2;
        {l3.g[4], l3.p[4]} = op(s2.g[4], s2.p[4], s2.g[0], s2.p[0]);
    end

    // A stage accepts when empty or when its successor drains it.
    assign ld3         = !v3 || ld_tail;
    assign ld2         = !v2 || ld3;
    assign ld1         = !v1 || ld2;
    assign bus.ready_o = ld1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            if (ld1) begin
                v1 <= bus.valid_i;
                s1 <= l1;
            end
            if (ld2) begin
                v2 <= v1;
                s2 <= l2;
            end
            if (ld3) begin
                v3 <= v2;
                s3 <= l3;
            end
        end
    end

    assign post_sum   = s3.po ^ s3.g[3:0];
    assign post_carry = s3.g[4];
`ifdef PREFIX_FLAGS_EN
    assign post_zero  = (post_sum == 4'd0);
    assign post_ovf   = s3.g[4] ^ s3.g[3];
`endif

    // Final group propagates are always zero since position 0 has p=0.
    assign unused_bits = ^{bus.prop_i[0], s3.p};

    if (OUT_REG) begin : g_out_reg
        logic       vo;
        logic [3:0] so;
        logic       co;

        assign ld_tail = !vo || bus.ready_i;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vo <= 1'b0;
                so <= 4'd0;
                co <= 1'b0;
            end else if (ld_tail) begin
                vo <= v3;
                so <= post_sum;
                co <= post_carry;
            end
        end

        assign bus.valid_o = vo;
        assign bus.sum_o   = so;
        assign bus.carry_o = co;

`ifdef PREFIX_FLAGS_EN
        logic zo;
        logic oo;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                zo <= 1'b0;
                oo <= 1'b0;
            end else if (ld_tail) begin
                zo <= post_zero;
                oo <= post_ovf;
            end
        end

        assign bus.zero_o = zo;
        assign bus.ovf_o  = oo;
`endif
    end else begin : g_out_comb
        assign ld_tail     = bus.ready_i;
        assign bus.valid_o = v3;
        assign bus.sum_o   = post_sum;
        assign bus.carry_o = post_carry;
`ifdef PREFIX_FLAGS_EN
        assign bus.zero_o  = post_zero;
        assign bus.ovf_o   = post_ovf;
`endif
    end

endmodule

// File: tb/tb_prefix_tree_pipe_4b.sv
// Directed and stream bench for prefix_tree_pipe_4b.
// Flag outputs are checked when PREFIX_FLAGS_EN is defined.
module tb_prefix_tree_pipe_4b;

    localparam bit OUT_REG = 1'b1;
    localparam int LAT     = OUT_REG ? 4 : 3;
    localparam int DEPTH   = OUT_REG ? 4 : 3;

    typedef struct {
        logic [4:0] prop;
        logic [4:0] gen;
        logic [3:0] sum;
        logic       carry;
        logic       zero;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [3:0] sum;
        logic       carry;
        logic       zero;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t mon_r;
    bit   mon_en = 1'b0;
    int   pops = 0;
    int   seen_valid = 0;
    int   run = 0;
    int   max_run = 0;

    prefix_tree_pipe_4b_if bus();

    prefix_tree_pipe_4b #(.OUT_REG(OUT_REG)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] a,
                                input logic [3:0] b,
                                input logic cin);
        vec_t       v;
        logic [4:0] s;
        logic [3:0] lo;
        s  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b0, cin};
        v.prop  = {a ^ b, 1'b0};
        v.gen   = {a & b, cin};
        v.sum   = s[3:0];
        v.carry = s[4];
        v.zero  = (s[3:0] == 4'd0);
        v.ovf   = s[4] ^ lo[3];
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        res_t r;
        r.sum   = v.sum;
        r.carry = v.carry;
        r.zero  = v.zero;
        r.ovf   = v.ovf;
        exp_q.push_back(r);
    endtask

    task automatic send(input vec_t v);
        bus.valid_i = 1'b1;
        bus.prop_i  = v.prop;
        bus.gen_i   = v.gen;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.ready_o) begin
                push_exp(v);
                @(negedge clk);
                bus.valid_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("send_timeout", 32'd0, 32'd1);
        bus.valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en && rst_n) begin
            if (bus.valid_o) begin
                seen_valid++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (bus.valid_o && bus.ready_i) begin
                check("mon_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_r = exp_q.pop_front();
                    pops++;
                    check("mon_sum", 32'(bus.sum_o), 32'(mon_r.sum));
                    check("mon_carry", 32'(bus.carry_o), 32'(mon_r.carry));
`ifdef PREFIX_FLAGS_EN
                    check("mon_zero", 32'(bus.zero_o), 32'(mon_r.zero));
                    check("mon_ovf", 32'(bus.ovf_o), 32'(mon_r.ovf));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        vec_t sv[5];
        vec_t v0;
        int   lat;
        int   acc;
        int   p0;
        int   sv0;

        tbl[0] = '{5'b01100, 5'b00010, 4'b1000, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{5'b11100, 5'b00010, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{5'b00000, 5'b00001, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{5'b00001, 5'b00001, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{5'b00000, 5'b10000, 4'b0000, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{5'b11110, 5'b00001, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{5'b01110, 5'b00000, 4'b0111, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{5'b11110, 5'b00000, 4'b1111, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{5'b11010, 5'b00101, 4'b0010, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{5'b00110, 5'b01001, 4'b1100, 1'b0, 1'b0, 1'b1};

        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.prop_i  = 5'd0;
        bus.gen_i   = 5'd0;
        bus.ready_i = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_sum", 32'(bus.sum_o), 32'd0);
        check("rst_carry", 32'(bus.carry_o), 32'd0);
`ifdef PREFIX_FLAGS_EN
        check("rst_zero", 32'(bus.zero_o), 32'd0);
        check("rst_ovf", 32'(bus.ovf_o), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(bus.ready_o), 32'd1);

        // Single transactions through an empty pipe.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.valid_i = 1'b1;
            bus.prop_i  = tbl[i].prop;
            bus.gen_i   = tbl[i].gen;
            #1;
            check("tbl_ready", 32'(bus.ready_o), 32'd1);
            @(negedge clk);
            bus.valid_i = 1'b0;
            lat = 1;
            while (!bus.valid_o && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            check("tbl_latency", 32'(lat), 32'(LAT));
            check("tbl_sum", 32'(bus.sum_o), 32'(tbl[i].sum));
            check("tbl_carry", 32'(bus.carry_o), 32'(tbl[i].carry));
`ifdef PREFIX_FLAGS_EN
            check("tbl_zero", 32'(bus.zero_o), 32'(tbl[i].zero));
            check("tbl_ovf", 32'(bus.ovf_o), 32'(tbl[i].ovf));
`endif
        end

        // Back-to-back random stream at full throughput.
        @(negedge clk);
        @(negedge clk);
        mon_en  = 1'b1;
        p0      = pops;
        run     = 0;
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            send(mk(4'($urandom_range(15, 0)),
                    4'($urandom_range(15, 0)),
                    1'($urandom_range(1, 0))));
        end
        drain("stream_drain");
        @(negedge clk);
        check("stream_count", 32'(pops - p0), 32'd8);
        check("stream_back_to_back", 32'(max_run), 32'd8);

        // Stall: the pipe fills to capacity, then holds its head.
        for (int k = 0; k < 5; k++) begin
            sv[k] = mk(4'(3 * k + 1), 4'(k + 5), 1'(k & 1));
        end
        p0          = pops;
        bus.ready_i = 1'b0;
        acc         = 0;
        for (int c = 0; c < 8 && acc < 5; c++) begin
            bus.valid_i = 1'b1;
            bus.prop_i  = sv[acc].prop;
            bus.gen_i   = sv[acc].gen;
            #1;
            if (bus.ready_o) begin
                push_exp(sv[acc]);
                acc++;
            end
            @(negedge clk);
        end
        check("stall_accepted", 32'(acc), 32'(DEPTH));
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_ready", 32'(bus.ready_o), 32'd0);
            check("stall_valid", 32'(bus.valid_o), 32'd1);
            check("stall_sum", 32'(bus.sum_o), 32'(sv[0].sum));
            check("stall_carry", 32'(bus.carry_o), 32'(sv[0].carry));
            @(negedge clk);
        end
        bus.ready_i = 1'b1;
        #1;
        check("stall_release_ready", 32'(bus.ready_o), 32'd1);
        if (bus.ready_o) push_exp(sv[4]);
        @(negedge clk);
        bus.valid_i = 1'b0;
        drain("stall_drain");
        @(negedge clk);
        check("stall_count", 32'(pops - p0), 32'd5);

        // Reset with results in flight discards them.
        mon_en = 1'b0;
        v0 = mk(4'd6, 4'd3, 1'b0);
        send(v0);
        send(mk(4'd2, 4'd2, 1'b1));
        send(mk(4'd11, 4'd1, 1'b0));
        @(negedge clk);
        check("inflight_valid", 32'(bus.valid_o), 32'd1);
        check("inflight_sum", 32'(bus.sum_o), 32'(v0.sum));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.valid_o), 32'd0);
        check("midrst_sum", 32'(bus.sum_o), 32'd0);
        check("midrst_carry", 32'(bus.carry_o), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.ready_o), 32'd1);
        sv0    = seen_valid;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        check("midrst_no_stale", 32'(seen_valid - sv0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
